// File: rtl/param_chan_bank.sv
// Multi-channel register bank: staged shadow writes, committed to live outputs by a one-channel-per-cycle sweep.
// Optional readback port enabled by defining PARAM_CHAN_BANK_READBACK_EN.
module param_chan_bank #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int K        = 0,
    parameter int STEP     = 0,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [CW-1:0]             wr_chan,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      commit,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
`ifdef PARAM_CHAN_BANK_READBACK_EN
    input  logic [CW-1:0]             rd_chan,
    output logic [WIDTH-1:0]          rd_data,
`endif
    output logic [CHANNELS*WIDTH-1:0] k
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(CHANNELS - 1);
    localparam logic [CW:0]   CHAN_LIM = (CW + 1)'(CHANNELS);

    state_t             state;
    logic [CW-1:0]      idx;
    logic [CHANNELS-1:0] dirty;
    logic [WIDTH-1:0]   shadow [CHANNELS];
    logic [WIDTH-1:0]   live   [CHANNELS];

    logic wr_fire;
    logic wr_in_range;

    function automatic logic [WIDTH-1:0] init_val(input int i);
        return WIDTH'(K + i * STEP);
    endfunction

    assign wr_fire     = wr_valid && wr_ready;
    // Extra bit so the compare also works when CHANNELS is a power of two.
    assign wr_in_range = {1'b0, wr_chan} < CHAN_LIM;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
        assign k[g*WIDTH +: WIDTH] = live[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: both value arrays are reset because their power-up contents are the
            // parameter-derived defaults that downstream logic depends on; they are small
            // flop arrays, not RAM, so a reset costs nothing structurally.
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= init_val(i);
                live[i]   <= init_val(i);
            end
            dirty    <= '0;
            idx      <= '0;
            state    <= IDLE;
            wr_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so the write below and the
            // commit decision in the same cycle both see pre-edge values; a write and
            // commit together still lands in the shadow before the sweep reads it.
            if (wr_fire) begin
                if (wr_in_range) begin
                    shadow[wr_chan] <= wr_data;
                    dirty[wr_chan]  <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end

            done <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (commit) begin
                        state    <= SCAN;
                        idx      <= '0;
                        busy     <= 1'b1;
                        wr_ready <= 1'b0;
                    end else begin
                        state    <= IDLE;
                        wr_ready <= 1'b1;
                    end
                end
                SCAN: begin
                    if (dirty[idx]) begin
                        live[idx]  <= shadow[idx];
                        dirty[idx] <= 1'b0;
                    end
                    if (idx == LAST_IDX) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        wr_ready <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef PARAM_CHAN_BANK_READBACK_EN
    logic rd_in_range;
    assign rd_in_range = {1'b0, rd_chan} < CHAN_LIM;

    // Forward a write firing this edge so readback shows it in the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (!rd_in_range) begin
            rd_data <= '0;
        end else if (wr_fire && wr_in_range && (wr_chan == rd_chan)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= shadow[rd_chan];
        end
    end
`endif

endmodule

// File: tb/tb_param_chan_bank.sv
// Scoreboard bench for param_chan_bank: 4-channel (K=5, STEP=3) and 3-channel (K=0, STEP=0) instances.
module tb_param_chan_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance: WIDTH=8, CHANNELS=4, K=5, STEP=3
    logic        wr_valid = 1'b0;
    logic        commit   = 1'b0;
    logic [1:0]  wr_chan  = '0;
    logic [7:0]  wr_data  = '0;
    logic        wr_ready, busy, done, err;
    logic [31:0] k;
    logic [1:0]  rd_chan  = '0;
    logic [7:0]  rd_data;

    // Second instance: WIDTH=8, CHANNELS=3, K=0, STEP=0
    logic        c3_wr_valid = 1'b0;
    logic        c3_commit   = 1'b0;
    logic [1:0]  c3_wr_chan  = '0;
    logic [7:0]  c3_wr_data  = '0;
    logic        c3_wr_ready, c3_busy, c3_done, c3_err;
    logic [23:0] c3_k;
    logic [1:0]  c3_rd_chan  = '0;
    logic [7:0]  c3_rd_data;

    param_chan_bank #(.WIDTH(8), .CHANNELS(4), .K(5), .STEP(3)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_chan(wr_chan), .wr_data(wr_data), .commit(commit), .busy(busy),
        .done(done), .err(err),
`ifdef PARAM_CHAN_BANK_READBACK_EN
        .rd_chan(rd_chan), .rd_data(rd_data),
`endif
        .k(k)
    );

    param_chan_bank #(.WIDTH(8), .CHANNELS(3), .K(0), .STEP(0)) dut3 (
        .clk(clk), .rst(rst), .wr_valid(c3_wr_valid), .wr_ready(c3_wr_ready),
        .wr_chan(c3_wr_chan), .wr_data(c3_wr_data), .commit(c3_commit), .busy(c3_busy),
        .done(c3_done), .err(c3_err),
`ifdef PARAM_CHAN_BANK_READBACK_EN
        .rd_chan(c3_rd_chan), .rd_data(c3_rd_data),
`endif
        .k(c3_k)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model of the 4-channel instance
    logic [7:0] m_shadow [4];
    logic [7:0] m_live   [4];
    bit         m_dirty  [4];

    typedef struct {
        logic [31:0] k;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb [$];

    function automatic logic [7:0] init_of(input int i);
        return 8'(5 + 3 * i);
    endfunction

    function automatic logic [31:0] pack_live();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_live[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = init_of(i);
            m_live[i]   = init_of(i);
            m_dirty[i]  = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int chan, input logic [7:0] data);
        vectors++;
        if (wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL write_ready ch%0d: got %b want 1", chan, wr_ready);
        end
        wr_valid = 1'b1;
        wr_chan  = 2'(chan);
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
        m_shadow[chan] = data;
        m_dirty[chan]  = 1'b1;
    endtask

    // Commit (optionally with a same-cycle write) and check every cycle of the sweep.
    // poke: hold a write request during SCAN and re-pulse commit mid-sweep; both must be ignored.
    task automatic run_sweep(input bit do_wr, input int wchan, input logic [7:0] wdata, input bit poke);
        exp_t e;
        int   n;
        commit = 1'b1;
        if (do_wr) begin
            wr_valid = 1'b1;
            wr_chan  = 2'(wchan);
            wr_data  = wdata;
            m_shadow[wchan] = wdata;
            m_dirty[wchan]  = 1'b1;
        end
        sb.push_back('{k: pack_live(), busy: 1'b1, done: 1'b0});
        for (int i = 0; i < 4; i++) begin
            if (m_dirty[i]) begin
                m_live[i]  = m_shadow[i];
                m_dirty[i] = 1'b0;
            end
            sb.push_back('{k: pack_live(), busy: (i < 3), done: (i == 3)});
        end
        sb.push_back('{k: pack_live(), busy: 1'b0, done: 1'b0});
        tick();
        commit   = 1'b0;
        wr_valid = 1'b0;
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (k !== e.k) begin
                miscompares++;
                $display("FAIL sweep_k step%0d: got %h want %h", n, k, e.k);
            end
            vectors++;
            if (busy !== e.busy || done !== e.done) begin
                miscompares++;
                $display("FAIL sweep_flags step%0d: busy/done got %b%b want %b%b", n, busy, done, e.busy, e.done);
            end
            vectors++;
            if (wr_ready !== !e.busy) begin
                miscompares++;
                $display("FAIL sweep_ready step%0d: got %b want %b", n, wr_ready, !e.busy);
            end
            if (poke) begin
                wr_valid = e.busy;
                wr_chan  = 2'd3;
                wr_data  = 8'h99;
                commit   = (n == 2);
            end
            n++;
            if (sb.size() > 0) tick();
        end
        wr_valid = 1'b0;
        commit   = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (k !== 32'h0E0B_0805) begin
            miscompares++;
            $display("FAIL reset_k: got %h want 0e0b0805", k);
        end
        vectors++;
        if (wr_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: ready/busy/done/err got %b%b%b%b want 0000", wr_ready, busy, done, err);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (wr_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: ready/busy/err got %b%b%b want 100", wr_ready, busy, err);
        end
    endtask

    task automatic test_staged_hold();
        do_write(2, 8'hAA);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (k !== pack_live()) begin
                miscompares++;
                $display("FAIL staged_hold cyc%0d: got %h want %h", i, k, pack_live());
            end
            tick();
        end
        run_sweep(1'b0, 0, 8'h00, 1'b0);
    endtask

    task automatic test_write_with_commit();
        run_sweep(1'b1, 0, 8'h01, 1'b0);
    endtask

    task automatic test_last_write_wins();
        do_write(1, 8'h10);
        do_write(1, 8'h20);
        run_sweep(1'b0, 0, 8'h00, 1'b1);
        // The write held during SCAN must not have staged anything for ch3.
        run_sweep(1'b0, 0, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid_sweep();
        for (int i = 0; i < 4; i++) do_write(i, 8'hFF);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        vectors++;
        if (k[7:0] !== 8'hFF || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_sweep_pre: k0=%h busy=%b want ff 1", k[7:0], busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        vectors++;
        if (k !== 32'h0E0B_0805 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_sweep_rst: k=%h busy=%b done=%b want 0e0b0805 0 0", k, busy, done);
        end
        tick();
        run_sweep(1'b0, 0, 8'h00, 1'b0);
    endtask

    task automatic test_three_channel();
        vectors++;
        if (c3_k !== 24'h0 || c3_err !== 1'b0 || c3_wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL c3_initial: k=%h err=%b ready=%b want 000000 0 1", c3_k, c3_err, c3_wr_ready);
        end
        c3_wr_valid = 1'b1;
        c3_wr_chan  = 2'd3;
        c3_wr_data  = 8'h07;
        tick();
        c3_wr_valid = 1'b0;
        vectors++;
        if (c3_err !== 1'b1 || c3_k !== 24'h0) begin
            miscompares++;
            $display("FAIL c3_out_of_range: err=%b k=%h want 1 000000", c3_err, c3_k);
        end
        c3_wr_valid = 1'b1;
        c3_wr_chan  = 2'd1;
        c3_wr_data  = 8'h33;
        c3_rd_chan  = 2'd1;
        tick();
        c3_wr_valid = 1'b0;
`ifdef PARAM_CHAN_BANK_READBACK_EN
        vectors++;
        if (c3_rd_data !== 8'h33) begin
            miscompares++;
            $display("FAIL c3_readback: got %h want 33", c3_rd_data);
        end
        c3_rd_chan = 2'd3;
        tick();
        vectors++;
        if (c3_rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL c3_readback_oor: got %h want 00", c3_rd_data);
        end
`endif
        tick();
        vectors++;
        if (c3_err !== 1'b1 || c3_k !== 24'h0) begin
            miscompares++;
            $display("FAIL c3_sticky: err=%b k=%h want 1 000000", c3_err, c3_k);
        end
    endtask

    initial begin
        test_reset();
        test_staged_hold();
        test_write_with_commit();
        test_last_write_wins();
        test_three_channel();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
